// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the multiply/divide unit.
//   mdu_op_e    - 3-bit operation code carried on operator_i
//   mdu_state_e - mdu_ctrl FSM state encoding
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_ITER,
    DIV_FIX,
    DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: restoring radix-2 divider datapath on unsigned magnitudes.
// One quotient bit per step_i cycle; last_o flags the final step.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start_i          - load dividend/divisor, clear remainder and counter
//   clear_i          - abandon the current division (counter back to 0)
//   step_i           - perform one iteration
//   dividend_i       - dividend magnitude
//   divisor_i        - divisor magnitude (never zero when started)
//   quotient_o       - quotient register
//   remainder_o      - remainder register
//   last_o           - high during the final iteration
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic [WORD_SIZE-1:0] dividend_i,
  input  logic [WORD_SIZE-1:0] divisor_i,
  output logic [WORD_SIZE-1:0] quotient_o,
  output logic [WORD_SIZE-1:0] remainder_o,
  output logic                 last_o
);

  localparam int unsigned CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  logic [WORD_SIZE-1:0] quo_q;
  logic [WORD_SIZE-1:0] rem_q;
  logic [WORD_SIZE-1:0] dvs_q;
  logic [CW-1:0]        cnt_q;

  logic [WORD_SIZE:0]   shifted;
  logic [WORD_SIZE-1:0] diff;
  logic                 fits;

  // Dividend bits shift out of the top of quo_q into the partial remainder,
  // while the new quotient bit shifts in at the bottom.
  always_comb begin
    shifted = {rem_q, quo_q[WORD_SIZE-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    // When fits is set the true difference is below the divisor, so the low
    // WORD_SIZE bits are exact.
    diff    = shifted[WORD_SIZE-1:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= fits ? diff : shifted[WORD_SIZE-1:0];
      quo_q <= {quo_q[WORD_SIZE-2:0], fits};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = step_i & (cnt_q == CW'(WORD_SIZE - 1));

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with valid/ready handshakes.
// Multiplies complete in two cycles; divides iterate one bit per cycle in
// mdu_div_iter and finish with a sign-correction cycle.
// Build option: define MDU_CTRL_DIV_EN to include the divider. Without it,
// DIV/DIVU/REM/REMU complete in one cycle with result 0.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   req_valid_i    - request present
//   req_ready_o    - request accepted when high together with req_valid_i
//   operator_i     - mdu_op_e operation code
//   operand_a_i    - rs1 value
//   operand_b_i    - rs2 value
//   kill_i         - flush: abandon any in-flight or pending operation
//   resp_valid_o   - result available
//   resp_ready_i   - consumer takes result
//   result_o       - result, meaningful while resp_valid_o is high
//   busy_o         - high whenever the FSM is not IDLE
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           operator_i,
  input  logic [WORD_SIZE-1:0] operand_a_i,
  input  logic [WORD_SIZE-1:0] operand_b_i,
  input  logic                 kill_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [WORD_SIZE-1:0] result_o,
  output logic                 busy_o
);

  mdu_state_e           state_q;
  mdu_op_e              op_q;
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 resp_valid_q;

  logic                 accept;
  logic                 a_sx;
  logic                 b_sx;
  logic [2*WORD_SIZE-1:0] prod;
  logic [WORD_SIZE-1:0] mul_res;

  assign req_ready_o  = (state_q == IDLE) & ~kill_i;
  assign accept       = req_valid_i & req_ready_o;
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = resp_valid_q;
  assign result_o     = result_q;

  // Operands are extended to full product width with the per-op signedness;
  // the low 2*WORD_SIZE bits of that product serve all four multiply flavours.
  always_comb begin
    a_sx = 1'b0;
    b_sx = 1'b0;
    case (op_q)
      MDU_MULH: begin
        a_sx = a_q[WORD_SIZE-1];
        b_sx = b_q[WORD_SIZE-1];
      end
      MDU_MULHSU: a_sx = a_q[WORD_SIZE-1];
      default: ;
    endcase
    prod = {{WORD_SIZE{a_sx}}, a_q} * {{WORD_SIZE{b_sx}}, b_q};
    if (op_q == MDU_MULH || op_q == MDU_MULHSU || op_q == MDU_MULHU) begin
      mul_res = prod[2*WORD_SIZE-1:WORD_SIZE];
    end else begin
      mul_res = prod[WORD_SIZE-1:0];
    end
  end

`ifdef MDU_CTRL_DIV_EN
  localparam logic [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

  logic                 signed_in;
  logic                 a_neg_in;
  logic                 b_neg_in;
  logic                 rem_in;
  logic                 div_zero_in;
  logic                 ovf_in;
  logic [WORD_SIZE-1:0] a_mag;
  logic [WORD_SIZE-1:0] b_mag;
  logic                 div_start;
  logic                 div_last;
  logic [WORD_SIZE-1:0] quo;
  logic [WORD_SIZE-1:0] rem;
  logic [WORD_SIZE-1:0] div_res;
  logic                 q_neg_q;
  logic                 r_neg_q;

  always_comb begin
    signed_in   = ~operator_i[0];
    rem_in      = operator_i[1];
    a_neg_in    = signed_in & operand_a_i[WORD_SIZE-1];
    b_neg_in    = signed_in & operand_b_i[WORD_SIZE-1];
    a_mag       = a_neg_in ? -operand_a_i : operand_a_i;
    b_mag       = b_neg_in ? -operand_b_i : operand_b_i;
    div_zero_in = (operand_b_i == '0);
    ovf_in      = signed_in & (operand_a_i == MOST_NEG) & (operand_b_i == '1);
    div_start   = accept & operator_i[2] & ~div_zero_in & ~ovf_in;
  end

  mdu_div_iter #(
    .WORD_SIZE (WORD_SIZE)
  ) u_div_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .clear_i     (kill_i),
    .step_i      (state_q == DIV_ITER),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (quo),
    .remainder_o (rem),
    .last_o      (div_last)
  );

  // Quotient negative iff operand signs differ; remainder follows the dividend.
  always_comb begin
    if (op_q == MDU_REM || op_q == MDU_REMU) begin
      div_res = r_neg_q ? -rem : rem;
    end else begin
      div_res = q_neg_q ? -quo : quo;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= MDU_MUL;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
`ifdef MDU_CTRL_DIV_EN
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
`endif
    end else if (kill_i) begin
      state_q      <= IDLE;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q <= mdu_op_e'(operator_i);
            a_q  <= operand_a_i;
            b_q  <= operand_b_i;
            if (operator_i[2]) begin
`ifdef MDU_CTRL_DIV_EN
              q_neg_q <= a_neg_in ^ b_neg_in;
              r_neg_q <= a_neg_in;
              if (div_zero_in) begin
                state_q      <= DONE;
                resp_valid_q <= 1'b1;
                result_q     <= rem_in ? operand_a_i : '1;
              end else if (ovf_in) begin
                state_q      <= DONE;
                resp_valid_q <= 1'b1;
                result_q     <= rem_in ? '0 : MOST_NEG;
              end else begin
                state_q <= DIV_ITER;
              end
`else
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              result_q     <= '0;
`endif
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
          result_q     <= mul_res;
        end
        DIV_ITER: begin
`ifdef MDU_CTRL_DIV_EN
          if (div_last) state_q <= DIV_FIX;
`else
          state_q <= IDLE;
`endif
        end
        DIV_FIX: begin
`ifdef MDU_CTRL_DIV_EN
          state_q      <= DONE;
          resp_valid_q <= 1'b1;
          result_q     <= div_res;
`else
          state_q <= IDLE;
`endif
        end
        DONE: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_pkg::*;

`ifdef MDU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  operator_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        kill_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        busy_o;

  mdu_ctrl #(.WORD_SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .operator_i   (operator_i),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .kill_i       (kill_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .result_o     (result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned acc;
  int unsigned seen;
  logic        got;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sbx, p;
    logic signed [31:0] sa32, sb32;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sbx = {{32{b[31]}}, b};
    sa32 = a;
    sb32 = b;
    case (op)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbx; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      default: begin
        if (!DIV_EN) return '0;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
          3'd4:    return sa32 / sb32;
          3'd5:    return a / b;
          3'd6:    return sa32 % sb32;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int unsigned model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (!DIV_EN) return 1;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present one request and return the accept cycle index.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned acc_o);
    @(negedge clk);
    for (int i = 0; i < 100 && !req_ready_o; i++) @(negedge clk);
    chk("req_ready_wait", req_ready_o, 1);
    req_valid_i = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    acc_o = cyc;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input int unsigned lat, input string tag);
    int unsigned a_c;
    issue(op, a, b, a_c);
    exp_q.push_back('{tag, res, lat, a_c});
  endtask

  // Wait (bounded) for the next response, compare against the scoreboard, then take it.
  task automatic collect();
    exp_t x;
    logic v;
    v = 1'b0;
    for (int i = 0; i < 100 && !v; i++) begin
      @(negedge clk);
      v = resp_valid_o;
    end
    x = exp_q.pop_front();
    chk({x.tag, "_valid"}, v, 1);
    if (v) begin
      chk({x.tag, "_res"}, result_o, x.res);
      chk({x.tag, "_lat"}, cyc - x.acc, x.lat);
      chk({x.tag, "_ready_lo"}, req_ready_o, 0);
      resp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      resp_ready_i = 1'b0;
      @(negedge clk);
      chk({x.tag, "_idle"}, {resp_valid_o, busy_o}, 2'b00);
    end
  endtask

  initial begin
    #2;
    chk("rst_valid", resp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_ready", req_ready_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Multiplies
    send(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, "mulh_m1"); collect();
    send(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu_max"); collect();
    send(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu_m1"); collect();
    send(MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, "mul_lo"); collect();
    send(MDU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh_min"); collect();

    // Divides
`ifdef MDU_CTRL_DIV_EN
    send(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2"); collect();
    send(MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2"); collect();
    send(MDU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2"); collect();
    send(MDU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34, "rem_7_m2"); collect();
    send(MDU_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7"); collect();
    send(MDU_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7"); collect();
    send(MDU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1"); collect();
    send(MDU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0"); collect();
    send(MDU_REMU, 32'd100, 32'd0, 32'd100, 1, "remu_by0"); collect();
    send(MDU_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, "div_by0"); collect();
    send(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf"); collect();
    send(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf"); collect();

    // Kill during division at iteration 10
    issue(MDU_DIVU, 32'd50, 32'd7, acc);
    repeat (10) @(negedge clk);
    chk("kill_div_busy", busy_o, 1);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    chk("kill_div_idle", {busy_o, resp_valid_o}, 2'b00);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid_o) seen++;
    end
    chk("kill_div_noresp", seen, 0);
`else
    send(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'd0, 1, "div_off"); collect();
    send(MDU_DIVU, 32'd100, 32'd0, 32'd0, 1, "divu_off"); collect();
    send(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_off"); collect();
    send(MDU_REMU, 32'd100, 32'd7, 32'd0, 1, "remu_off"); collect();
`endif
    send(MDU_MUL, 32'd6, 32'd7, 32'd42, 2, "mul_6x7"); collect();

    // Kill during MUL: no response follows
    issue(MDU_MUL, 32'd5, 32'd5, acc);
    @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid_o || busy_o) seen++;
    end
    chk("kill_mul_noresp", seen, 0);

    // kill_i together with req_valid_i in IDLE: nothing accepted
    @(negedge clk);
    kill_i = 1'b1;
    req_valid_i = 1'b1;
    operator_i = MDU_MUL;
    #1;
    chk("kill_idle_ready", req_ready_o, 0);
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    req_valid_i = 1'b0;
    chk("kill_idle_busy", busy_o, 0);

    // Reset in the middle of a multiply: no response after release
    issue(MDU_MUL, 32'd9, 32'd9, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid_o) seen++;
    end
    chk("rst_mid_noresp", seen, 0);

    // Back-pressure in DONE, then reset while the response is held
    send(MDU_MUL, 32'd3, 32'd4, 32'd12, 2, "mul_hold");
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = resp_valid_o;
    end
    e = exp_q.pop_front();
    chk("mul_hold_valid", got, 1);
    chk("mul_hold_lat", cyc - e.acc, e.lat);
    req_valid_i = 1'b1;
    operator_i  = MDU_MULHU;
    operand_a_i = 32'hFFFF_FFFF;
    operand_b_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("mul_hold_res", result_o, e.res);
      chk("mul_hold_vr", {resp_valid_o, req_ready_o}, 2'b10);
      @(negedge clk);
    end
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("mul_hold_rst_valid", resp_valid_o, 0);
    chk("mul_hold_rst_result", result_o, 0);
    chk("mul_hold_rst_ready", {busy_o, req_ready_o}, 2'b01);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid_o) seen++;
    end
    chk("mul_hold_rst_noresp", seen, 0);

    // Random operations against the reference model
    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (n % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
      send(rop, ra, rb, model_res(rop, ra, rb), model_lat(rop, ra, rb), "rand");
      collect();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  1  request present.
REQ-005 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-006 SHALL have port operator_i  input  3  mdu_op_e operation code.
REQ-007 SHALL have port operand_a_i  input  WORD_SIZE  rs1 value.
REQ-008 SHALL have port operand_b_i  input  WORD_SIZE  rs2 value.
REQ-009 SHALL have port kill_i  input  1  abort in-flight or pending operation (pipeline flush).
REQ-010 SHALL have port resp_valid_o  output  1  result available.
REQ-011 SHALL have port resp_ready_i  input  1  consumer takes result.
REQ-012 SHALL have port result_o  output  WORD_SIZE  result, valid only while resp_valid_o high.
REQ-013 SHALL have port busy_o  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV_ITER, DIV_FIX, DONE.
REQ-015 SHALL drive req_ready_o = (state==IDLE) & ~kill_i; accept = req_valid_i & req_ready_o, latching operator and operands.
REQ-016 MUL/MULH/MULHSU/MULHU: IDLE->MUL->DONE; resp_valid_o high in the 2nd cycle after the accept cycle.
REQ-017 SHALL return low WORD_SIZE bits for MUL; high WORD_SIZE bits of signed x signed (MULH), signed x unsigned (MULHSU), unsigned x unsigned (MULHU) 2*WORD_SIZE-bit product.
REQ-018 DIV/DIVU/REM/REMU: IDLE->DIV_ITER, WORD_SIZE iterations of restoring radix-2 on magnitudes, ->DIV_FIX (sign correction) ->DONE; resp_valid_o high in cycle accept+WORD_SIZE+2.
REQ-019 Signed ops: quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-020 Divisor zero: IDLE->DONE directly, result quotient all-ones, remainder = operand_a; resp_valid_o in cycle accept+1.
REQ-021 Signed overflow (a = most-negative, b = -1) on DIV/REM: IDLE->DONE directly, quotient = most-negative, remainder = 0.
REQ-022 DONE holds resp_valid_o and result_o stable until resp_ready_i; then ->IDLE; no new accept in DONE cycle.
REQ-023 kill_i in any state: next state IDLE, resp_valid_o low next cycle, result discarded; kill_i with req_valid_i in IDLE: no accept.
REQ-024 Unused operator codes SHALL complete as MUL (no hang).

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, iteration counter 0, resp_valid_o 0, busy_o 0, result_o 0, req_ready_o follows IDLE (1 when kill_i low).
REQ-026 Reset mid-operation SHALL drop the operation with no response emitted after release.

Configuration
REQ-027 Macro MDU_CTRL_DIV_EN defined: divider and DIV_ITER/DIV_FIX states present per REQ-018..021.
REQ-028 Macro MDU_CTRL_DIV_EN undefined: divider logic absent; DIV/DIVU/REM/REMU go IDLE->DONE with result 0, resp_valid_o in cycle accept+1.

Structure
REQ-029 Package mdu_pkg SHALL hold mdu_op_e (MDU_MUL=0, MDU_MULH=1, MDU_MULHSU=2, MDU_MULHU=3, MDU_DIV=4, MDU_DIVU=5, MDU_REM=6, MDU_REMU=7) and the mdu_ctrl state enum.
REQ-030 Sub-module mdu_div_iter SHALL hold the restoring-division remainder/quotient shift registers and counter; mdu_ctrl holds FSM, multiplier, sign fix, handshake.

Verification
REQ-031 MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0x00000000 in cycle accept+2; MULHU same operands -> 0xFFFFFFFE.
REQ-032 DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD at cycle accept+34; REM same -> 0xFFFFFFFF.
REQ-033 DIVU a=100, b=0 -> 0xFFFFFFFF at accept+1; REMU a=100, b=0 -> 100.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; both at accept+1.
REQ-035 DIVU 50/7 started, kill_i pulsed at iteration 10 -> IDLE next cycle, no resp_valid_o, next MUL 6x7 -> 42.
REQ-036 MUL 3x4 with resp_ready_i low 5 cycles -> result 12 held stable, req_ready_o low until handshake, rst_n pulse in DONE clears resp_valid_o immediately.
